// File: rtl/mem_boot_loader_if.sv
// mem_boot_loader_if: control, ROM, stream and memory-write signals of the boot loader
// master: loader side (drives rom_addr, rx_ready, mem_*, core_reset, done, error, checksum)
// slave : environment side (drives start, mode, rom_data, rx_valid, rx_data)
interface mem_boot_loader_if #(
    parameter int ROM_AW = 8
);
    logic              start;
    logic              mode;
    logic [ROM_AW-1:0] rom_addr;
    logic [7:0]        rom_data;
    logic              rx_valid;
    logic [7:0]        rx_data;
    logic              rx_ready;
    logic [15:0]       mem_addr;
    logic [7:0]        mem_data;
    logic              mem_write;
    logic              core_reset;
    logic              done;
    logic              error;
    logic [7:0]        checksum;
    modport master (
        input  start, mode, rom_data, rx_valid, rx_data,
        output rom_addr, rx_ready, mem_addr, mem_data, mem_write, core_reset, done, error, checksum
    );
    modport slave (
        output start, mode, rom_data, rx_valid, rx_data,
        input  rom_addr, rx_ready, mem_addr, mem_data, mem_write, core_reset, done, error, checksum
    );
endinterface

// File: rtl/mem_boot_loader.sv
// mem_boot_loader: fills data memory from a ROM copy or a framed byte stream, holding the core in reset until done
// clk, rst : clock, asynchronous active-high reset
// bus      : mem_boot_loader_if.master (start/mode, ROM port, rx stream, memory write port, status)
module mem_boot_loader #(
    parameter int          IMAGE_SIZE = 256,
    parameter int          ROM_AW     = 8,
    parameter logic [15:0] BASE_ADDR  = 16'h0000,
    parameter int          WRITE_HOLD = 1,
    parameter bit          AUTO_START = 1'b1
) (
    input  logic                clk,
    input  logic                rst,
    mem_boot_loader_if.master   bus
);
    typedef enum logic [3:0] {
        S_IDLE, S_FETCH, S_WRITE, S_LEN_LO, S_LEN_HI, S_DATA, S_CSUM, S_DONE, S_ERROR
    } state_t;
    state_t      r_state, w_next;
    logic [16:0] r_index;
    logic [15:0] r_len;
    logic [7:0]  r_sum, r_data;
    logic [3:0]  r_hold;
    logic        r_mode, r_auto;
    logic        w_go, w_ready, w_rx, w_hold_end, w_last;
    logic [16:0] w_idx_inc;
    logic [15:0] w_len;
    logic [7:0]  w_wdata;
    // r_auto fires a single load on the first clock after reset release
    assign w_go       = (r_state inside {S_IDLE, S_DONE, S_ERROR}) && (bus.start || r_auto);
    assign w_ready    = r_state inside {S_LEN_LO, S_LEN_HI, S_DATA, S_CSUM};
    assign w_rx       = bus.rx_valid && w_ready;
    assign w_hold_end = r_hold == 4'(WRITE_HOLD - 1);
    assign w_idx_inc  = r_index + 17'd1;
    assign w_len      = {bus.rx_data, r_len[7:0]};
    assign w_last     = r_mode ? (w_idx_inc == {1'b0, r_len}) : (w_idx_inc == 17'(IMAGE_SIZE));
    // ROM data comes straight off the synchronous ROM register; stream data is captured in DATA
    assign w_wdata    = (r_state == S_WRITE && !r_mode) ? bus.rom_data : r_data;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE, S_DONE, S_ERROR: if (w_go) w_next = bus.mode ? S_LEN_LO : S_FETCH;
            S_FETCH:  w_next = S_WRITE;
            S_WRITE:  if (w_hold_end) w_next = w_last ? (r_mode ? S_CSUM : S_DONE) : (r_mode ? S_DATA : S_FETCH);
            S_LEN_LO: if (w_rx) w_next = S_LEN_HI;
            S_LEN_HI: if (w_rx) w_next = ({1'b0, w_len} > 17'(IMAGE_SIZE)) ? S_ERROR : (w_len == 16'd0 ? S_CSUM : S_DATA);
            S_DATA:   if (w_rx) w_next = S_WRITE;
            S_CSUM:   if (w_rx) w_next = (bus.rx_data == r_sum) ? S_DONE : S_ERROR;
            default:  w_next = S_IDLE;
        endcase
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_index <= '0;
            r_len   <= '0;
            r_sum   <= '0;
            r_data  <= '0;
            r_hold  <= '0;
            r_mode  <= 1'b0;
            r_auto  <= AUTO_START;
        end else begin
            r_auto <= 1'b0;
            r_hold <= (r_state == S_WRITE && !w_hold_end) ? r_hold + 4'd1 : 4'd0;
            if (w_go) begin
                r_index <= '0;
                r_sum   <= '0;
                r_mode  <= bus.mode;
            end
            if (r_state == S_WRITE && w_hold_end) begin
                r_sum   <= r_sum + w_wdata;
                r_index <= w_idx_inc;
            end
            if (r_state == S_LEN_LO && w_rx) r_len[7:0]  <= bus.rx_data;
            if (r_state == S_LEN_HI && w_rx) r_len[15:8] <= bus.rx_data;
            if (r_state == S_DATA && w_rx)   r_data      <= bus.rx_data;
        end
    end
    always_comb begin
        bus.rom_addr   = r_index[ROM_AW-1:0];
        bus.rx_ready   = w_ready;
        bus.mem_addr   = BASE_ADDR + r_index[15:0];
        bus.mem_data   = w_wdata;
        bus.mem_write  = r_state == S_WRITE;
        bus.core_reset = r_state != S_DONE;
        bus.done       = r_state == S_DONE;
        bus.error      = r_state == S_ERROR;
        bus.checksum   = r_sum;
    end
endmodule

// File: tb/tb_mem_boot_loader.sv
// tb_mem_boot_loader: directed checks of ROM copy, stream frames, errors, restart and reset for mem_boot_loader
module tb_mem_boot_loader;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;
    int total = 0;
    int bad = 0;
    logic [1:0] start_v = '0, mode_v = '0, valid_v = '0;
    logic [7:0] data_v [2] = '{8'h00, 8'h00};
    logic [1:0] ready_v;
    mem_boot_loader_if #(.ROM_AW(2)) bus_a ();
    mem_boot_loader_if #(.ROM_AW(8)) bus_b ();
    mem_boot_loader #(.IMAGE_SIZE(4), .ROM_AW(2), .BASE_ADDR(16'h8000), .WRITE_HOLD(1), .AUTO_START(1'b1))
        dut_a (.clk(clk), .rst(rst), .bus(bus_a.master));
    mem_boot_loader #(.IMAGE_SIZE(256), .ROM_AW(8), .BASE_ADDR(16'h0000), .WRITE_HOLD(3), .AUTO_START(1'b0))
        dut_b (.clk(clk), .rst(rst), .bus(bus_b.master));
    assign bus_a.start    = start_v[0];
    assign bus_a.mode     = mode_v[0];
    assign bus_a.rx_valid = valid_v[0];
    assign bus_a.rx_data  = data_v[0];
    assign bus_b.start    = start_v[1];
    assign bus_b.mode     = mode_v[1];
    assign bus_b.rx_valid = valid_v[1];
    assign bus_b.rx_data  = data_v[1];
    assign bus_b.rom_data = 8'h00;
    assign ready_v = {bus_b.rx_ready, bus_a.rx_ready};
    logic [7:0] rom_a [0:3] = '{8'h11, 8'h22, 8'h33, 8'h44};
    always_ff @(posedge clk) bus_a.rom_data <= rom_a[bus_a.rom_addr];
    logic [7:0] mem_a [0:3];
    logic [7:0] mem_b [0:255];
    int wr_a = 0, wr_b = 0, wa_bad = 0, wb_bad = 0;
    always @(posedge clk) begin
        if (bus_a.mem_write === 1'b1) begin
            mem_a[bus_a.mem_addr[1:0]] <= bus_a.mem_data;
            wr_a <= wr_a + 1;
            if (bus_a.mem_addr[15:2] != 14'h2000) wa_bad <= wa_bad + 1;
        end
        if (bus_b.mem_write === 1'b1) begin
            mem_b[bus_b.mem_addr[7:0]] <= bus_b.mem_data;
            wr_b <= wr_b + 1;
            if (bus_b.mem_addr[15:8] != 8'h00) wb_bad <= wb_bad + 1;
        end
    end
    task automatic pulse_start(input int d, input logic m);
        @(negedge clk);
        start_v[d] = 1'b1;
        mode_v[d] = m;
        @(negedge clk);
        start_v[d] = 1'b0;
    endtask
    task automatic send(input int d, input logic [7:0] v);
        valid_v[d] = 1'b1;
        data_v[d] = v;
        for (int n = 0; n < 40 && ready_v[d] !== 1'b1; n++) @(negedge clk);
        total++;
        if (ready_v[d] !== 1'b1) begin
            bad++;
            $display("FAIL send_timeout dut=%0d byte=%h rx_ready=%b want 1", d, v, ready_v[d]);
        end else begin
            @(posedge clk);
            @(negedge clk);
        end
        valid_v[d] = 1'b0;
    endtask
    task automatic test_reset;
        repeat (2) @(negedge clk);
        total++; if (bus_a.mem_addr !== 16'h8000) begin bad++; $display("FAIL reset_mem_addr got %h want 8000", bus_a.mem_addr); end
        total++; if ({bus_a.rom_addr, bus_a.rx_ready, bus_a.mem_write, bus_a.core_reset, bus_a.done, bus_a.error} !== 7'b0000100) begin
            bad++; $display("FAIL reset_ctl got %b want 0000100", {bus_a.rom_addr, bus_a.rx_ready, bus_a.mem_write, bus_a.core_reset, bus_a.done, bus_a.error}); end
        total++; if ({bus_a.mem_data, bus_a.checksum} !== 16'h0000) begin bad++; $display("FAIL reset_data got %h want 0000", {bus_a.mem_data, bus_a.checksum}); end
        total++; if ({bus_b.core_reset, bus_b.done, bus_b.error} !== 3'b100) begin bad++; $display("FAIL reset_b got %b want 100", {bus_b.core_reset, bus_b.done, bus_b.error}); end
    endtask
    task automatic test_rom_copy;
        int n;
        logic cr_prev;
        rst = 1'b0;
        cr_prev = 1'b1;
        for (n = 1; n <= 50; n++) begin
            @(negedge clk);
            if (bus_a.done === 1'b1) break;
            cr_prev = bus_a.core_reset;
        end
        total++; if (n != 9) begin bad++; $display("FAIL rom_done_latency got %0d want 9", n); end
        total++; if ({cr_prev, bus_a.core_reset, bus_a.error} !== 3'b100) begin bad++; $display("FAIL rom_core_reset got %b want 100", {cr_prev, bus_a.core_reset, bus_a.error}); end
        total++; if (bus_a.checksum !== 8'hAA) begin bad++; $display("FAIL rom_checksum got %h want aa", bus_a.checksum); end
        total++; if ({mem_a[0], mem_a[1], mem_a[2], mem_a[3]} !== 32'h11223344) begin bad++; $display("FAIL rom_mem got %h want 11223344", {mem_a[0], mem_a[1], mem_a[2], mem_a[3]}); end
        total++; if (wr_a != 4 || wa_bad != 0) begin bad++; $display("FAIL rom_writes got %0d/%0d want 4/0", wr_a, wa_bad); end
    endtask
    task automatic test_stream_ok;
        int w0;
        w0 = wr_a;
        pulse_start(0, 1'b1);
        send(0, 8'h03); send(0, 8'h00); send(0, 8'h01); send(0, 8'h02); send(0, 8'h03); send(0, 8'h06);
        total++; if ({bus_a.done, bus_a.error, bus_a.core_reset} !== 3'b100) begin bad++; $display("FAIL stream_ok_status got %b want 100", {bus_a.done, bus_a.error, bus_a.core_reset}); end
        total++; if ({mem_a[0], mem_a[1], mem_a[2], mem_a[3]} !== 32'h01020344) begin bad++; $display("FAIL stream_ok_mem got %h want 01020344", {mem_a[0], mem_a[1], mem_a[2], mem_a[3]}); end
        total++; if (wr_a - w0 != 3 || bus_a.checksum !== 8'h06) begin bad++; $display("FAIL stream_ok_count got %0d/%h want 3/06", wr_a - w0, bus_a.checksum); end
    endtask
    task automatic test_stream_bad;
        int w0;
        w0 = wr_a;
        pulse_start(0, 1'b1);
        send(0, 8'h02); send(0, 8'h00); send(0, 8'h10); send(0, 8'h20); send(0, 8'h31);
        repeat (2) @(negedge clk);
        total++; if ({bus_a.done, bus_a.error, bus_a.core_reset} !== 3'b011) begin bad++; $display("FAIL stream_bad_status got %b want 011", {bus_a.done, bus_a.error, bus_a.core_reset}); end
        total++; if ({mem_a[0], mem_a[1], mem_a[2], mem_a[3]} !== 32'h10200344) begin bad++; $display("FAIL stream_bad_mem got %h want 10200344", {mem_a[0], mem_a[1], mem_a[2], mem_a[3]}); end
        total++; if (wr_a - w0 != 2 || bus_a.checksum !== 8'h30) begin bad++; $display("FAIL stream_bad_count got %0d/%h want 2/30", wr_a - w0, bus_a.checksum); end
    endtask
    task automatic test_len_too_big;
        pulse_start(1, 1'b1);
        send(1, 8'h01); send(1, 8'h01);
        total++; if ({bus_b.error, bus_b.done, bus_b.rx_ready, bus_b.core_reset} !== 4'b1001) begin bad++; $display("FAIL len_big_status got %b want 1001", {bus_b.error, bus_b.done, bus_b.rx_ready, bus_b.core_reset}); end
        total++; if (wr_b != 0) begin bad++; $display("FAIL len_big_writes got %0d want 0", wr_b); end
    endtask
    task automatic test_start_ignored;
        int n;
        pulse_start(0, 1'b0);
        total++; if ({bus_a.error, bus_a.rx_ready, bus_a.mem_write} !== 3'b000) begin bad++; $display("FAIL restart_fetch got %b want 000", {bus_a.error, bus_a.rx_ready, bus_a.mem_write}); end
        @(negedge clk);
        total++; if (bus_a.mem_write !== 1'b1) begin bad++; $display("FAIL restart_write got %b want 1", bus_a.mem_write); end
        start_v[0] = 1'b1;
        mode_v[0] = 1'b1;
        @(negedge clk);
        start_v[0] = 1'b0;
        mode_v[0] = 1'b0;
        total++; if ({bus_a.rx_ready, bus_a.mem_write, bus_a.rom_addr} !== 4'b0001) begin bad++; $display("FAIL start_ignored got %b want 0001", {bus_a.rx_ready, bus_a.mem_write, bus_a.rom_addr}); end
        for (n = 3; n <= 50; n++) begin
            @(negedge clk);
            if (bus_a.done === 1'b1) break;
        end
        total++; if (n != 8) begin bad++; $display("FAIL reload_latency got %0d want 8", n); end
        total++; if ({mem_a[0], mem_a[1], mem_a[2], mem_a[3]} !== 32'h11223344 || bus_a.checksum !== 8'hAA) begin
            bad++; $display("FAIL reload_mem got %h/%h want 11223344/aa", {mem_a[0], mem_a[1], mem_a[2], mem_a[3]}, bus_a.checksum); end
    endtask
    task automatic test_reset_mid;
        int n;
        logic [1:0] ra;
        pulse_start(0, 1'b0);
        repeat (4) @(negedge clk);
        total++; if (bus_a.rom_addr !== 2'd2) begin bad++; $display("FAIL mid_rom_addr got %0d want 2", bus_a.rom_addr); end
        @(negedge clk);
        total++; if ({bus_a.mem_write, bus_a.mem_addr} !== 17'h18002) begin bad++; $display("FAIL mid_write got %h want 18002", {bus_a.mem_write, bus_a.mem_addr}); end
        #2 rst = 1'b1;
        #1;
        total++; if ({bus_a.rom_addr, bus_a.rx_ready, bus_a.mem_write, bus_a.core_reset, bus_a.done, bus_a.error} !== 7'b0000100) begin
            bad++; $display("FAIL mid_reset_ctl got %b want 0000100", {bus_a.rom_addr, bus_a.rx_ready, bus_a.mem_write, bus_a.core_reset, bus_a.done, bus_a.error}); end
        total++; if ({bus_a.mem_addr, bus_a.mem_data, bus_a.checksum} !== 32'h80000000) begin bad++; $display("FAIL mid_reset_data got %h want 80000000", {bus_a.mem_addr, bus_a.mem_data, bus_a.checksum}); end
        @(negedge clk);
        rst = 1'b0;
        ra = 2'd3;
        for (n = 1; n <= 50; n++) begin
            @(negedge clk);
            if (n == 1) ra = bus_a.rom_addr;
            if (bus_a.done === 1'b1) break;
        end
        total++; if (ra !== 2'd0 || n != 9) begin bad++; $display("FAIL mid_restart got addr=%0d lat=%0d want 0/9", ra, n); end
        total++; if (bus_a.checksum !== 8'hAA) begin bad++; $display("FAIL mid_checksum got %h want aa", bus_a.checksum); end
    endtask
    task automatic test_rx_hold;
        int w0;
        w0 = wr_b;
        pulse_start(1, 1'b1);
        send(1, 8'h02); send(1, 8'h00); send(1, 8'h5A);
        valid_v[1] = 1'b1;
        data_v[1] = 8'hA5;
        for (int k = 0; k < 3; k++) begin
            total++; if ({bus_b.rx_ready, bus_b.mem_write} !== 2'b01) begin bad++; $display("FAIL hold_%0d got %b want 01", k, {bus_b.rx_ready, bus_b.mem_write}); end
            @(negedge clk);
        end
        total++; if ({bus_b.rx_ready, bus_b.mem_write} !== 2'b10) begin bad++; $display("FAIL hold_end got %b want 10", {bus_b.rx_ready, bus_b.mem_write}); end
        send(1, 8'hA5); send(1, 8'hFF);
        total++; if ({bus_b.done, bus_b.error, bus_b.checksum} !== 10'h2FF) begin bad++; $display("FAIL hold_status got %h want 2ff", {bus_b.done, bus_b.error, bus_b.checksum}); end
        total++; if (wr_b - w0 != 6 || wb_bad != 0 || {mem_b[0], mem_b[1]} !== 16'h5AA5) begin
            bad++; $display("FAIL hold_mem got %0d/%0d/%h want 6/0/5aa5", wr_b - w0, wb_bad, {mem_b[0], mem_b[1]}); end
    endtask
    initial begin
        #100000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1);
    end
    initial begin
        test_reset;
        test_rom_copy;
        test_stream_ok;
        test_stream_bad;
        test_len_too_big;
        test_start_ignored;
        test_reset_mid;
        test_rx_hold;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
